// File: rtl/contador_multicanal_pkg.sv
// Shared helpers for counter blocks: mode encoding and next-value arithmetic
// (raw step, clamp or wrap). Values travel as int so callers never wrap silently.
package pkg_contadores;

  localparam int MODO_SATURA   = 0;
  localparam int MODO_ENVUELVE = 1;

  function automatic int paso_crudo(input int v, input int paso, input logic sumar);
    return sumar ? (v + paso) : (v - paso);
  endfunction

  function automatic logic fuera_de_limites(input int r, input int inf, input int sup);
    return (r > sup) || (r < inf);
  endfunction

  // Brings a raw result back into [inf, sup]; wrap assumes |excursion| <= range.
  function automatic int ajustar(input int r, input int inf, input int sup, input int modo);
    int rango;
    rango = sup - inf + 1;
    if (r > sup) return (modo == MODO_ENVUELVE) ? (r - rango) : sup;
    if (r < inf) return (modo == MODO_ENVUELVE) ? (r + rango) : inf;
    return r;
  endfunction

  function automatic int siguiente_valor(input int v, input int paso, input logic sumar,
                                         input int inf, input int sup, input int modo);
    return ajustar(paso_crudo(v, paso, sumar), inf, sup, modo);
  endfunction

endpackage

// File: rtl/FlipFlopD_Habilitado.sv
// Enabled D register with asynchronous active-high reset to a configurable value.
module FlipFlopD_Habilitado #(
  parameter int unsigned                 BITS_EN_REGISTRO = 8,
  parameter logic [BITS_EN_REGISTRO-1:0] VALOR_RESET      = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        habilitar_i,
  input  logic [BITS_EN_REGISTRO-1:0] d_i,
  output logic [BITS_EN_REGISTRO-1:0] q_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            q_o <= VALOR_RESET;
    else if (habilitar_i) q_o <= d_i;
  end

endmodule

// File: rtl/paso_limitado.sv
// Combinational next value and overflow flag for one counter step.
module paso_limitado
  import pkg_contadores::*;
#(
  parameter int unsigned BITS_VALOR      = 8,
  parameter int unsigned BITS_PASO       = 4,
  parameter int          LIMITE_INFERIOR = 0,
  parameter int          LIMITE_SUPERIOR = 255,
  parameter int          MODO            = MODO_SATURA
) (
  input  logic [BITS_VALOR-1:0] valor_i,
  input  logic                  sumar_i,
  input  logic [BITS_PASO-1:0]  paso_i,
  output logic [BITS_VALOR-1:0] valor_sig_c,
  output logic                  desborde_c
);

  int crudo;

  always_comb begin
    crudo       = paso_crudo(int'(valor_i), int'(paso_i), sumar_i);
    valor_sig_c = BITS_VALOR'(ajustar(crudo, LIMITE_INFERIOR, LIMITE_SUPERIOR, MODO));
    desborde_c  = fuera_de_limites(crudo, LIMITE_INFERIOR, LIMITE_SUPERIOR);
  end

endmodule

// File: rtl/contador_multicanal.sv
// Bank of up/down counters: one write (load or step) and one registered read per clock.
module contador_multicanal
  import pkg_contadores::*;
#(
  parameter int unsigned BITS_VALOR      = 8,
  parameter int unsigned CANALES         = 4,
  parameter int unsigned BITS_PASO       = 4,
  parameter int          LIMITE_INFERIOR = 0,
  parameter int          LIMITE_SUPERIOR = (1 << BITS_VALOR) - 1,
  parameter int          MODO            = MODO_SATURA,
  parameter int          VALOR_INICIAL   = LIMITE_INFERIOR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       actualizar,
  input  logic                       operacion,
  input  logic [BITS_PASO-1:0]       paso,
  input  logic                       cargar,
  input  logic [BITS_VALOR-1:0]      valor_carga,
  input  logic [$clog2(CANALES)-1:0] canal_escritura,
  input  logic [$clog2(CANALES)-1:0] canal_lectura,
  output logic [BITS_VALOR-1:0]      valor_actual,
  output logic                       en_limite,
  output logic                       desborde
);

  localparam int unsigned         BITS_CANAL    = $clog2(CANALES);
  localparam int                  RANGO         = LIMITE_SUPERIOR - LIMITE_INFERIOR + 1;
  localparam logic [BITS_VALOR-1:0] INF_V       = BITS_VALOR'(LIMITE_INFERIOR);
  localparam logic [BITS_VALOR-1:0] SUP_V       = BITS_VALOR'(LIMITE_SUPERIOR);
  localparam logic [BITS_VALOR-1:0] INI_V       = BITS_VALOR'(VALOR_INICIAL);
  localparam logic                EN_LIMITE_INI = (INI_V == INF_V) || (INI_V == SUP_V);

  logic [BITS_VALOR-1:0] valores [CANALES];
  logic [CANALES-1:0]    habilitar;
  logic                  escritura_valida_c, lectura_valida_c, escribe_c;
  logic [BITS_VALOR-1:0] valor_escrito_c, valor_sig_c, valor_d_c, carga_limitada_c, valor_leido_c;
  logic                  desborde_c;

  logic [BITS_VALOR-1:0] valor_actual_q, valor_actual_d;
  logic                  en_limite_q, en_limite_d;
  logic                  desborde_q, desborde_d;

  // Channel select; out-of-range indices neither write nor read storage.
  always_comb begin
    escritura_valida_c = 32'(canal_escritura) < CANALES;
    lectura_valida_c   = 32'(canal_lectura) < CANALES;
    escribe_c          = escritura_valida_c && (cargar || actualizar);
    valor_escrito_c    = '0;
    valor_leido_c      = '0;
    if (escritura_valida_c) valor_escrito_c = valores[canal_escritura];
    if (lectura_valida_c)   valor_leido_c   = valores[canal_lectura];
  end

  // One arithmetic unit suffices: at most one channel is written per cycle.
  paso_limitado #(
    .BITS_VALOR     (BITS_VALOR),
    .BITS_PASO      (BITS_PASO),
    .LIMITE_INFERIOR(LIMITE_INFERIOR),
    .LIMITE_SUPERIOR(LIMITE_SUPERIOR),
    .MODO           (MODO)
  ) u_paso (
    .valor_i    (valor_escrito_c),
    .sumar_i    (operacion),
    .paso_i     (paso),
    .valor_sig_c(valor_sig_c),
    .desborde_c (desborde_c)
  );

  always_comb begin
    carga_limitada_c = BITS_VALOR'(ajustar(int'(valor_carga), LIMITE_INFERIOR,
                                           LIMITE_SUPERIOR, MODO_SATURA));
    valor_d_c        = cargar ? carga_limitada_c : valor_sig_c;
  end

  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    assign habilitar[i] = escribe_c && (canal_escritura == BITS_CANAL'(i));

    FlipFlopD_Habilitado #(
      .BITS_EN_REGISTRO(BITS_VALOR),
      .VALOR_RESET     (INI_V)
    ) u_registro (
      .clk        (clk),
      .reset      (reset),
      .habilitar_i(habilitar[i]),
      .d_i        (valor_d_c),
      .q_o        (valores[i])
    );
  end

  always_comb begin
    valor_actual_d = valor_leido_c;
    en_limite_d    = (valor_leido_c == INF_V) || (valor_leido_c == SUP_V);
    desborde_d     = escritura_valida_c && actualizar && !cargar && desborde_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valor_actual_q <= INI_V;
      en_limite_q    <= EN_LIMITE_INI;
      desborde_q     <= 1'b0;
    end else begin
      valor_actual_q <= valor_actual_d;
      en_limite_q    <= en_limite_d;
      desborde_q     <= desborde_d;
    end
  end

  assign valor_actual = valor_actual_q;
  assign en_limite    = en_limite_q;
  assign desborde     = desborde_q;

  // Wrap arithmetic only folds back once, so a step wider than the range is meaningless.
  paso_dentro_de_rango: assert property (@(posedge clk) disable iff (reset)
    !(MODO == MODO_ENVUELVE && actualizar && !cargar && int'(paso) > RANGO))
    else $error("paso %0d exceeds wrap range %0d", paso, RANGO);

endmodule

// File: tb/tb_contador_multicanal.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; INF=2, SUP=12.
module tb_contador_multicanal;

  localparam int INF = 2;
  localparam int SUP = 12;
  localparam int RNG = SUP - INF + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       actualizar, operacion, cargar;
  logic [2:0] paso;
  logic [3:0] valor_carga;
  logic [1:0] canal_escritura, canal_lectura;
  logic [3:0] va_sat, va_env;
  logic       el_sat, el_env, de_sat, de_env;

  typedef struct {
    int v_sat; int l_sat; int d_sat;
    int v_env; int l_env; int d_env;
  } esperado_t;

  esperado_t cola[$];
  string     etiquetas[$];
  int        m_sat[4];
  int        m_env[4];
  int        total = 0;
  int        bad   = 0;

  always #5 clk = ~clk;

  contador_multicanal #(
    .BITS_VALOR(4), .CANALES(4), .BITS_PASO(3),
    .LIMITE_INFERIOR(INF), .LIMITE_SUPERIOR(SUP), .MODO(0)
  ) dut_sat (
    .clk(clk), .reset(reset), .actualizar(actualizar), .operacion(operacion),
    .paso(paso), .cargar(cargar), .valor_carga(valor_carga),
    .canal_escritura(canal_escritura), .canal_lectura(canal_lectura),
    .valor_actual(va_sat), .en_limite(el_sat), .desborde(de_sat)
  );

  contador_multicanal #(
    .BITS_VALOR(4), .CANALES(4), .BITS_PASO(3),
    .LIMITE_INFERIOR(INF), .LIMITE_SUPERIOR(SUP), .MODO(1)
  ) dut_env (
    .clk(clk), .reset(reset), .actualizar(actualizar), .operacion(operacion),
    .paso(paso), .cargar(cargar), .valor_carga(valor_carga),
    .canal_escritura(canal_escritura), .canal_lectura(canal_lectura),
    .valor_actual(va_env), .en_limite(el_env), .desborde(de_env)
  );

  task automatic comprobar(input string tag, input int obs, input int esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  function automatic int modelo(input int v, input int p, input bit suma, input int modo,
                                output bit ov);
    int r;
    r  = suma ? v + p : v - p;
    ov = (r > SUP) || (r < INF);
    if (r > SUP) r = (modo == 1) ? r - RNG : SUP;
    else if (r < INF) r = (modo == 1) ? r + RNG : INF;
    return r;
  endfunction

  function automatic int lim(input int v);
    return (v == INF || v == SUP) ? 1 : 0;
  endfunction

  task automatic comprobar_reset(input string tag);
    comprobar({tag, "_v_sat"}, int'(va_sat), 2);
    comprobar({tag, "_l_sat"}, int'(el_sat), 1);
    comprobar({tag, "_d_sat"}, int'(de_sat), 0);
    comprobar({tag, "_v_env"}, int'(va_env), 2);
    comprobar({tag, "_l_env"}, int'(el_env), 1);
    comprobar({tag, "_d_env"}, int'(de_env), 0);
  endtask

  // Drive one cycle, predict its outputs into the scoreboard, then pop and compare.
  task automatic ciclo(input string tag, input bit ld, input bit up, input bit op,
                       input int p, input int vc, input int cw, input int cr);
    esperado_t e, x;
    string     t;
    bit        ov_s, ov_e;
    ov_s    = 1'b0;
    ov_e    = 1'b0;
    e.v_sat = m_sat[cr];
    e.l_sat = lim(m_sat[cr]);
    e.v_env = m_env[cr];
    e.l_env = lim(m_env[cr]);
    if (ld) begin
      int c;
      c = (vc < INF) ? INF : ((vc > SUP) ? SUP : vc);
      m_sat[cw] = c;
      m_env[cw] = c;
    end else if (up) begin
      m_sat[cw] = modelo(m_sat[cw], p, op, 0, ov_s);
      m_env[cw] = modelo(m_env[cw], p, op, 1, ov_e);
    end
    e.d_sat = int'(ov_s);
    e.d_env = int'(ov_e);
    cola.push_back(e);
    etiquetas.push_back(tag);

    cargar          = ld;
    actualizar      = up;
    operacion       = op;
    paso            = 3'(p);
    valor_carga     = 4'(vc);
    canal_escritura = 2'(cw);
    canal_lectura   = 2'(cr);
    @(posedge clk);
    #1;
    x = cola.pop_front();
    t = etiquetas.pop_front();
    comprobar({t, "_v_sat"}, int'(va_sat), x.v_sat);
    comprobar({t, "_l_sat"}, int'(el_sat), x.l_sat);
    comprobar({t, "_d_sat"}, int'(de_sat), x.d_sat);
    comprobar({t, "_v_env"}, int'(va_env), x.v_env);
    comprobar({t, "_l_env"}, int'(el_env), x.l_env);
    comprobar({t, "_d_env"}, int'(de_env), x.d_env);
  endtask

  task automatic reiniciar_modelo();
    for (int i = 0; i < 4; i++) begin
      m_sat[i] = INF;
      m_env[i] = INF;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {actualizar, operacion, cargar} = 3'b000;
    paso = '0; valor_carga = '0; canal_escritura = '0; canal_lectura = '0;
    reiniciar_modelo();
    repeat (2) @(posedge clk);
    #1;
    comprobar_reset("rst");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) ciclo("s1_rd", 0, 0, 0, 0, 0, 0, i);

    for (int i = 0; i < 3; i++) ciclo("s2_add5", 0, 1, 1, 5, 0, 1, 1);
    ciclo("s2_rd", 0, 0, 0, 0, 0, 0, 1);

    ciclo("s3_ld11", 1, 0, 0, 0, 11, 2, 2);
    ciclo("s3_add3", 0, 1, 1, 3, 0, 2, 2);
    ciclo("s3_sub4", 0, 1, 0, 4, 0, 2, 2);
    ciclo("s3_rd", 0, 0, 0, 0, 0, 0, 2);
    ciclo("s3_rd2", 0, 0, 0, 0, 0, 0, 2);

    ciclo("s4_wr_rd", 0, 1, 1, 1, 0, 0, 0);
    ciclo("s4_rd0", 0, 0, 0, 0, 0, 0, 0);
    ciclo("s4_rd3", 0, 0, 0, 0, 0, 0, 3);

    ciclo("s5_ld_up", 1, 1, 1, 7, 15, 1, 1);
    ciclo("s5_rd1", 0, 0, 0, 0, 0, 0, 1);
    ciclo("s5_ld0", 1, 0, 0, 0, 0, 3, 3);
    ciclo("s5_paso0", 0, 1, 0, 0, 0, 0, 3);
    ciclo("s5_sub7", 0, 1, 0, 7, 0, 0, 0);
    for (int i = 0; i < 4; i++) ciclo("s5_rd", 0, 0, 0, 0, 0, 0, i);

    for (int i = 0; i < 12; i++)
      ciclo("s6_burst", 1'($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // In-flight update on ch1 is overlapped by reset across the sampling edge.
    cargar = 1'b0; actualizar = 1'b1; operacion = 1'b1; paso = 3'd7;
    canal_escritura = 2'd1; canal_lectura = 2'd1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    comprobar_reset("s6_rst");
    reiniciar_modelo();
    @(posedge clk);
    #1;
    reset = 1'b0;
    actualizar = 1'b0;
    for (int i = 0; i < 4; i++) ciclo("s6_rd", 0, 0, 0, 0, 0, 0, i);
    ciclo("s6_first_wr", 0, 1, 1, 3, 0, 2, 2);
    ciclo("s6_rd2", 0, 0, 0, 0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
